div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter_if.sv | 49 ++++
 rtl/div_arbiter.sv | 173 +++++++++++++++++
 tb/tb_div_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester, divider and response signals of div_arbiter.
// slave = arbiter side, master = requesters/divider/environment side.
interface div_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 16
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TAG_DEPTH) + 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [64*N_REQ-1:0] req_dividend;
    logic [32*N_REQ-1:0] req_divisor;

    logic                div_input_valid;
    logic [63:0]         div_dividend;
    logic [31:0]         div_divisor;
    logic                div_dividend_tready;
    logic                div_divisor_tready;
    logic [63:0]         div_quotient;
    logic                div_quotient_valid;

    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_quotient;
    logic                rsp_dbz;
    logic [CW-1:0]       outstanding;
    logic                err_orphan;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        input  div_dividend_tready, div_divisor_tready,
        input  div_quotient, div_quotient_valid,
        output req_ready,
        output div_input_valid, div_dividend, div_divisor,
        output rsp_valid, rsp_id, rsp_quotient, rsp_dbz,
        output outstanding, err_orphan
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        output div_dividend_tready, div_divisor_tready,
        output div_quotient, div_quotient_valid,
        input  req_ready,
        input  div_input_valid, div_dividend, div_divisor,
        input  rsp_valid, rsp_id, rsp_quotient, rsp_dbz,
        input  outstanding, err_orphan
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin share of one pipelined divider among N_REQ
// requesters, with an in-order tag FIFO routing results back to owners.
// Ports: clk, rst_n (async, active-low), bus (div_arbiter_if.slave):
//   req_* operand handshake, div_* divider side, rsp_* results,
//   outstanding count and sticky err_orphan.
module div_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    div_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TAG_DEPTH) + 1;
    localparam int PW  = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [63:0]      dvd_q;
    logic [31:0]      dvs_q;
    logic [IDW-1:0]   own_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   grant;
    logic             found;
    logic             issue;
    logic             pop;
    logic             capture;
    logic             slot_free;
    logic [CW:0]      occ;
    logic [N_REQ-1:0] ready;

    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [IDW:0]     mem [TAG_DEPTH];
    logic [IDW:0]     push_tag;
    logic [IDW:0]     head_tag;

    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [63:0]      rsp_q_q;
    logic             rsp_dbz_q;
    logic             err_q;

    assign issue = (state_q == HOLD)
                 && bus.div_dividend_tready
                 && bus.div_divisor_tready;

    // A result with nothing outstanding may still claim a tag being
    // pushed in the same cycle.
    assign pop = bus.div_quotient_valid && ((cnt_q != '0) || issue);

    assign push_tag = {own_q, (dvs_q == 32'd0)};
    assign head_tag = (cnt_q == '0) ? push_tag : mem[rd_q];

    // Occupancy after this cycle's pop; the held operand counts as a tag.
    assign occ = {1'b0, cnt_q}
               + {{CW{1'b0}}, (state_q == HOLD)}
               - {{CW{1'b0}}, pop};
    assign slot_free = occ < (CW+1)'(TAG_DEPTH);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: capture = found && slot_free;
            HOLD: capture = issue && found && slot_free;
        endcase
        if (capture) begin
            state_d = HOLD;
        end else if (issue) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ready = '0;
        if (capture) begin
            ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            own_q   <= '0;
            ptr_q   <= IDW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            if (capture) begin
                dvd_q <= bus.req_dividend[64*grant +: 64];
                dvs_q <= bus.req_divisor[32*grant +: 32];
                own_q <= grant;
                ptr_q <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            if (issue) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (issue && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!issue && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            mem[wr_q] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_dbz_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= pop;
            if (pop) begin
                rsp_id_q  <= head_tag[IDW:1];
                rsp_dbz_q <= head_tag[0];
                rsp_q_q   <= bus.div_quotient;
            end
            if (bus.div_quotient_valid && !pop) begin
                err_q <= 1'b1;
            end
        end
    end

    // req_ready must read 0 while reset is held, even with requests up.
    assign bus.req_ready       = rst_n ? ready : '0;
    assign bus.div_input_valid = (state_q == HOLD);
    assign bus.div_dividend    = dvd_q;
    assign bus.div_divisor     = dvs_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_id          = rsp_id_q;
    assign bus.rsp_quotient    = rsp_q_q;
    assign bus.rsp_dbz         = rsp_dbz_q;
    assign bus.outstanding     = cnt_q;
    assign bus.err_orphan      = err_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: random and directed stimulus for div_arbiter checked
// against a transaction-level model (held operand, tag queue, divider queue).
module tb_div_arbiter;
    localparam int N  = 4;
    localparam int TD = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_arbiter_if #(.N_REQ(N), .TAG_DEPTH(TD)) bus ();

    div_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int id;
        bit dbz;
    } tag_t;

    typedef struct {
        logic [63:0] q;
        int          due;
    } res_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] r_dvd [N];
    logic [31:0] r_dvs [N];

    bit          m_hold;
    int          m_own;
    logic [63:0] m_dvd;
    logic [31:0] m_dvs;
    int          m_last;
    tag_t        m_tags [$];
    bit          m_err;
    bit          e_rv;
    tag_t        e_tag;
    logic [63:0] e_q;

    res_t        dq [$];
    int          lat    = 1;
    int          cyc    = 0;
    bit          inject = 0;
    int          maxo;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void gen_op(int i);
        r_dvd[i] = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       r_dvs[i] = 32'd0;
            1, 2:    r_dvs[i] = 32'($urandom_range(1, 15));
            default: r_dvs[i] = $urandom;
        endcase
    endfunction

    function automatic int rr_pick(int last, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_hold = 0;
        m_own  = 0;
        m_dvd  = '0;
        m_dvs  = '0;
        m_last = N - 1;
        m_tags.delete();
        m_err  = 0;
        e_rv   = 0;
    endfunction

    // One clock: caller has set req_valid/treadys just after a negedge.
    task automatic tick();
        bit           issue_m;
        bit           pop_m;
        bit           free_m;
        int           g;
        logic [N-1:0] exp_rdy;
        tag_t         it;
        res_t         r;

        bus.div_quotient_valid = 1'b0;
        bus.div_quotient       = {$urandom, $urandom};
        if (inject) begin
            bus.div_quotient_valid = 1'b1;
            inject = 0;
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
            r = dq.pop_front();
            bus.div_quotient_valid = 1'b1;
            bus.div_quotient       = r.q;
        end
        for (int i = 0; i < N; i++) begin
            bus.req_dividend[64*i +: 64] = r_dvd[i];
            bus.req_divisor[32*i +: 32]  = r_dvs[i];
        end
        #1;

        issue_m = m_hold && bus.div_dividend_tready && bus.div_divisor_tready;
        pop_m   = bus.div_quotient_valid && (m_tags.size() > 0 || issue_m);
        free_m  = (m_tags.size() + int'(m_hold) - int'(pop_m)) < TD;
        g       = rr_pick(m_last, bus.req_valid);
        exp_rdy = '0;
        if ((!m_hold || issue_m) && free_m && g >= 0) exp_rdy[g] = 1'b1;

        chk("rsp_valid", bus.rsp_valid, e_rv);
        if (e_rv) begin
            chk("rsp_id", bus.rsp_id, e_tag.id);
            chk("rsp_dbz", bus.rsp_dbz, e_tag.dbz);
            chk("rsp_quotient", bus.rsp_quotient, e_q);
        end
        chk("outstanding", bus.outstanding, m_tags.size());
        chk("err_orphan", bus.err_orphan, m_err);
        chk("in_valid", bus.div_input_valid, m_hold);
        if (m_hold) begin
            chk("div_dividend", bus.div_dividend, m_dvd);
            chk("div_divisor", bus.div_divisor, m_dvs);
        end
        chk("req_ready", bus.req_ready, exp_rdy);

        if (issue_m) begin
            it.id  = m_own;
            it.dbz = (m_dvs == 32'd0);
            m_tags.push_back(it);
            r.q   = (m_dvs == 32'd0) ? '1 : m_dvd / {32'd0, m_dvs};
            r.due = cyc + lat;
            dq.push_back(r);
            m_hold = 0;
        end
        e_rv = pop_m;
        if (pop_m) begin
            e_tag = m_tags.pop_front();
            e_q   = bus.div_quotient;
        end else if (bus.div_quotient_valid) begin
            m_err = 1;
        end
        if (exp_rdy != '0) begin
            m_hold = 1;
            m_own  = g;
            m_dvd  = r_dvd[g];
            m_dvs  = r_dvs[g];
            m_last = g;
            gen_op(g);
        end

        @(negedge clk);
        cyc++;
        if (int'(bus.outstanding) > maxo) maxo = int'(bus.outstanding);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_ready"}, bus.req_ready, '0);
        chk({tag, "_in_valid"}, bus.div_input_valid, 1'b0);
        chk({tag, "_dividend"}, bus.div_dividend, '0);
        chk({tag, "_divisor"}, bus.div_divisor, '0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        chk({tag, "_rsp_id"}, bus.rsp_id, '0);
        chk({tag, "_rsp_q"}, bus.rsp_quotient, '0);
        chk({tag, "_rsp_dbz"}, bus.rsp_dbz, 1'b0);
        chk({tag, "_outstanding"}, bus.outstanding, '0);
        chk({tag, "_err"}, bus.err_orphan, 1'b0);
    endtask

    // Mid-cycle reset pulse; pending divider results stay queued.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        chk_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < N; i++) gen_op(i);
        model_reset();
        bus.req_valid           = '1;
        bus.req_dividend        = '0;
        bus.req_divisor         = '0;
        bus.div_dividend_tready = 1'b1;
        bus.div_divisor_tready  = 1'b1;
        bus.div_quotient        = '0;
        bus.div_quotient_valid  = 1'b0;
        #1;
        chk_reset_outputs("rst_init");
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;

        // single request from requester 2
        lat = 3;
        r_dvd[2] = 64'd100;
        r_dvs[2] = 32'd7;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        ticks(8);

        // all requesters continuously valid
        lat = 5;
        bus.req_valid = '1;
        ticks(24);
        bus.req_valid = '0;
        ticks(10);

        // divider stalls while an operand is held
        bus.req_valid = '1;
        bus.div_dividend_tready = 1'b0;
        bus.div_divisor_tready  = 1'b0;
        ticks(6);
        bus.div_dividend_tready = 1'b1;
        tick();
        bus.div_dividend_tready = 1'b0;
        bus.div_divisor_tready  = 1'b1;
        tick();
        bus.div_dividend_tready = 1'b1;
        ticks(3);
        bus.req_valid = '0;
        ticks(10);

        // long divider latency fills the tag FIFO
        lat  = 40;
        maxo = 0;
        bus.req_valid = '1;
        ticks(80);
        chk("max_outstanding", maxo, TD);
        bus.req_valid = '0;
        ticks(50);

        // divide by zero then a normal divide from requester 1
        lat = 2;
        r_dvd[1] = 64'd55;
        r_dvs[1] = 32'd0;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        tick();
        r_dvd[1] = 64'd55;
        r_dvs[1] = 32'd5;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        ticks(6);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 12);
            bus.req_valid           = N'($urandom);
            bus.div_dividend_tready = ($urandom_range(0, 3) != 0);
            bus.div_divisor_tready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req_valid           = '0;
        bus.div_dividend_tready = 1'b1;
        bus.div_divisor_tready  = 1'b1;
        ticks(30);

        // orphan result, then reset with results still in the divider
        inject = 1;
        tick();
        ticks(2);
        chk("orphan_flag", bus.err_orphan, 1'b1);
        lat = 6;
        bus.req_valid = '1;
        ticks(8);
        do_reset();
        bus.req_valid = '0;
        ticks(15);
        chk("orphan_after_reset", bus.err_orphan, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
